// File: rtl/div_sequencer_pkg.sv
// ============================================================================
// div_sequencer_pkg : shared state encoding, sizes and adder helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_t;

  // 32-bit adder returning {carry_out, sum}; the architecture is left to synthesis.
  function automatic logic [32:0] cla_32(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  function automatic logic [31:0] negate_32(input logic [31:0] x);
    return 32'(cla_32(~x, 32'd0, 1'b1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_sequencer_if.sv
// ============================================================================
// div_sequencer_if : start/operand/result bundle of the divider controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic                 ctrl_DIV;
  logic [DIV_WIDTH-1:0] data_operandA;
  logic [DIV_WIDTH-1:0] data_operandB;
  logic [DIV_WIDTH-1:0] data_result;
  logic [DIV_WIDTH-1:0] data_remainder;
  logic                 data_resultRDY;
  logic                 data_exception;
  logic                 busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_resultRDY, data_exception, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_resultRDY, data_exception, busy
  );

endinterface

`default_nettype wire

// File: rtl/div_sequencer_step.sv
// ============================================================================
// div_sequencer_step : one combinational restoring-division step
// Rev 1.0
// ============================================================================
`default_nettype none

module div_sequencer_step
  import div_sequencer_pkg::*;
(
  input  wire logic [31:0] rem,
  input  wire logic [31:0] quo,
  input  wire logic [31:0] divisor,
  output logic      [31:0] rem_next,
  output logic      [31:0] quo_next
);

  logic [63:0] shifted;
  logic [32:0] trial;

  // rem stays below |B| <= 2^31, so the shifted remainder always fits 32 bits.
  assign shifted  = {rem, quo} << 1;
  assign trial    = cla_32(shifted[63:32], ~divisor, 1'b1);
  assign rem_next = trial[32] ? trial[31:0] : shifted[63:32];
  assign quo_next = shifted[31:0] | {31'd0, trial[32]};

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// div_sequencer : fixed-latency signed 32-bit restoring divider controller
// Rev 1.0
// ============================================================================
`default_nettype none

module div_sequencer
  import div_sequencer_pkg::*;
(
  input  wire logic       clock,
  input  wire logic       resetn,
  div_sequencer_if.slave  bus
);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [31:0]          dividend;
  logic [31:0]          divisor;
  logic [31:0]          div_mag;
  logic [31:0]          rem;
  logic [31:0]          quo;
  logic                 quo_neg;
  logic                 rem_neg;
  logic                 div_zero;
  logic [31:0]          result_q;
  logic [31:0]          remainder_q;
  logic                 ready_q;
  logic                 exception_q;
  logic                 busy_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] neg_a;
  logic [31:0] neg_b;
  logic [31:0] neg_quo;
  logic [31:0] neg_rem;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  assign neg_a   = negate_32(dividend);
  assign neg_b   = negate_32(divisor);
  assign neg_quo = negate_32(quo);
  assign neg_rem = negate_32(rem);
  assign abs_a   = dividend[31] ? neg_a : dividend;
  assign abs_b   = divisor[31]  ? neg_b : divisor;

  div_sequencer_step u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (div_mag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dividend    <= '0;
      divisor     <= '0;
      div_mag     <= '0;
      rem         <= '0;
      quo         <= '0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      div_zero    <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
      exception_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          ready_q <= 1'b0;
          if (bus.ctrl_DIV) begin
            dividend <= bus.data_operandA;
            divisor  <= bus.data_operandB;
            quo_neg  <= bus.data_operandA[31] ^ bus.data_operandB[31];
            rem_neg  <= bus.data_operandA[31];
            busy_q   <= 1'b1;
            state    <= ST_PREP;
          end else begin
            state    <= ST_IDLE;
          end
        end
        ST_PREP: begin
          quo      <= abs_a;
          rem      <= '0;
          div_mag  <= abs_b;
          div_zero <= (divisor == 32'd0);
          cnt      <= '0;
          state    <= ST_ITER;
        end
        ST_ITER: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == DIV_CNT_W'(DIV_ITERS - 1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          // A zero divisor still runs all iterations to keep latency constant.
          if (div_zero) begin
            result_q    <= '0;
            remainder_q <= dividend;
            exception_q <= 1'b1;
          end else begin
            result_q    <= quo_neg ? neg_quo : quo;
            remainder_q <= rem_neg ? neg_rem : rem;
            exception_q <= 1'b0;
          end
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = remainder_q;
  assign bus.data_resultRDY = ready_q;
  assign bus.data_exception = exception_q;
  assign bus.busy           = busy_q;

endmodule

`default_nettype wire
